// File: rtl/axi_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_burst_mem_slave
//
// AXI4-style burst memory responder used as the simulation main-memory
// endpoint behind the data cache. Reads and writes are served by two
// independent state machines sharing one word array.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   AR: araddr, arvalid, arburst, arlen, arsize -> arready
//   R : rdata, rresp, rvalid, rlast            <- rready
//   AW: awaddr, awvalid, awburst, awlen        -> awready
//   W : wdata, wlast, wstrb, wvalid            -> wready
//   B : bresp, bvalid                          <- bready
//
// Responses: OKAY (00), SLVERR (10) for reserved burst types or a wlast that
// disagrees with the beat count, DECERR (11) for addresses outside the array.
// ---------------------------------------------------------------------------
module axi_burst_mem_slave #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  // read address channel
  input  logic [31:0]             araddr,
  input  logic                    arvalid,
  input  logic [1:0]              arburst,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  output logic                    arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  output logic                    rlast,
  input  logic                    rready,
  // write address channel
  input  logic [31:0]             awaddr,
  input  logic                    awvalid,
  input  logic [1:0]              awburst,
  input  logic [7:0]              awlen,
  output logic                    awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    wlast,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  // write response channel
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd8;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Write bursts have no size field: every write beat covers a full word.
  localparam logic [31:0] W_STEP = 32'(STRB_W);

  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 3);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // -------------------------------------------------------------------------
  // Read channel
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  r_state_t    r_state_reg;
  logic [31:0] r_addr_reg;     // address of the beat currently presented
  logic [7:0]  r_len_reg;
  logic [7:0]  r_cnt_reg;
  logic [2:0]  r_size_reg;
  logic [1:0]  r_burst_reg;
  logic [7:0]  r_wait_reg;

  logic [31:0]      r_addr_next;
  logic [31:0]      rd_fetch_addr;
  logic [1:0]       rd_fetch_burst;
  logic [1:0]       rd_fetch_resp;
  logic [IDX_W-1:0] rd_fetch_idx;

  assign r_addr_next = (r_burst_reg == BURST_INCR) ? r_addr_reg + (32'd1 << r_size_reg)
                                                   : r_addr_reg;

  // Address of the beat that will be loaded into rdata at the next edge:
  // the AR address on a zero-wait accept, the latched start address when
  // leaving R_WAIT, or the following beat when the current one is taken.
  always_comb begin
    rd_fetch_addr  = r_addr_reg;
    rd_fetch_burst = r_burst_reg;
    if (r_state_reg == R_IDLE) begin
      rd_fetch_addr  = araddr;
      rd_fetch_burst = arburst;
    end else if (r_state_reg == R_DATA) begin
      rd_fetch_addr = r_addr_next;
    end
  end

  assign rd_fetch_idx  = word_index(rd_fetch_addr);
  assign rd_fetch_resp = !addr_in_range(rd_fetch_addr) ? RESP_DECERR :
                         rd_fetch_burst[1]             ? RESP_SLVERR : RESP_OKAY;

  // rdata is loaded only at beat boundaries, so it is naturally held while
  // the master stalls. The array read happens before any same-edge write
  // lands, so a colliding read returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_reg <= R_IDLE;
      r_addr_reg  <= '0;
      r_len_reg   <= '0;
      r_cnt_reg   <= '0;
      r_size_reg  <= '0;
      r_burst_reg <= '0;
      r_wait_reg  <= '0;
      arready     <= 1'b1;
      rvalid      <= 1'b0;
      rlast       <= 1'b0;
      rdata       <= '0;
      rresp       <= RESP_OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (arvalid) begin
            r_addr_reg  <= araddr;
            r_len_reg   <= arlen;
            r_size_reg  <= arsize;
            r_burst_reg <= arburst;
            r_cnt_reg   <= '0;
            arready     <= 1'b0;
            if (READ_LATENCY <= 1) begin
              rdata       <= (rd_fetch_resp == RESP_OKAY) ? mem[rd_fetch_idx] : '0;
              rresp       <= rd_fetch_resp;
              rlast       <= (arlen == 8'd0);
              rvalid      <= 1'b1;
              r_state_reg <= R_DATA;
            end else begin
              r_wait_reg  <= 8'(READ_LATENCY - 2);
              r_state_reg <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_wait_reg == 8'd0) begin
            rdata       <= (rd_fetch_resp == RESP_OKAY) ? mem[rd_fetch_idx] : '0;
            rresp       <= rd_fetch_resp;
            rlast       <= (r_len_reg == 8'd0);
            rvalid      <= 1'b1;
            r_state_reg <= R_DATA;
          end else begin
            r_wait_reg <= r_wait_reg - 8'd1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_cnt_reg == r_len_reg) begin
              rvalid      <= 1'b0;
              rlast       <= 1'b0;
              arready     <= 1'b1;
              r_state_reg <= R_IDLE;
            end else begin
              r_addr_reg <= r_addr_next;
              r_cnt_reg  <= r_cnt_reg + 8'd1;
              rdata      <= (rd_fetch_resp == RESP_OKAY) ? mem[rd_fetch_idx] : '0;
              rresp      <= rd_fetch_resp;
              rlast      <= ((r_cnt_reg + 8'd1) == r_len_reg);
            end
          end
        end
        default: begin
          r_state_reg <= R_IDLE;
          arready     <= 1'b1;
          rvalid      <= 1'b0;
          rlast       <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Write channel
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t    w_state_reg;
  logic [31:0] w_addr_reg;
  logic [7:0]  w_len_reg;
  logic [7:0]  w_cnt_reg;
  logic [1:0]  w_burst_reg;
  logic        w_decerr_reg;   // sticky across the burst
  logic        w_slverr_reg;   // sticky across the burst

  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_final_beat;
  logic             w_beat_dec;
  logic             w_beat_slv;
  logic             mem_we;

  assign w_in_range   = addr_in_range(w_addr_reg);
  assign w_idx        = word_index(w_addr_reg);
  assign w_final_beat = (w_cnt_reg == w_len_reg);
  assign w_beat_dec   = !w_in_range;
  // The beat counter alone ends the burst; wlast is only cross-checked.
  assign w_beat_slv   = (wlast != w_final_beat);
  assign mem_we       = (w_state_reg == W_DATA) && wvalid && w_in_range;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_reg  <= W_IDLE;
      w_addr_reg   <= '0;
      w_len_reg    <= '0;
      w_cnt_reg    <= '0;
      w_burst_reg  <= '0;
      w_decerr_reg <= 1'b0;
      w_slverr_reg <= 1'b0;
      awready      <= 1'b1;
      wready       <= 1'b0;
      bvalid       <= 1'b0;
      bresp        <= RESP_OKAY;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (awvalid) begin
            w_addr_reg   <= awaddr;
            w_len_reg    <= awlen;
            w_burst_reg  <= awburst;
            w_cnt_reg    <= '0;
            w_decerr_reg <= 1'b0;
            w_slverr_reg <= awburst[1];
            awready      <= 1'b0;
            wready       <= 1'b1;
            w_state_reg  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            w_decerr_reg <= w_decerr_reg | w_beat_dec;
            w_slverr_reg <= w_slverr_reg | w_beat_slv;
            if (w_final_beat) begin
              wready      <= 1'b0;
              bvalid      <= 1'b1;
              bresp       <= (w_decerr_reg | w_beat_dec) ? RESP_DECERR :
                             (w_slverr_reg | w_beat_slv) ? RESP_SLVERR : RESP_OKAY;
              w_state_reg <= W_RESP;
            end else begin
              w_cnt_reg <= w_cnt_reg + 8'd1;
              if (w_burst_reg == BURST_INCR) begin
                w_addr_reg <= w_addr_reg + W_STEP;
              end
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid      <= 1'b0;
            awready     <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: begin
          w_state_reg <= W_IDLE;
          awready     <= 1'b1;
          wready      <= 1'b0;
          bvalid      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
module tb_axi_burst_mem_slave;

  localparam int          MEM_WORDS = 1024;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          RL        = 2;
  localparam logic [1:0]  FIXED     = 2'b00;
  localparam logic [1:0]  INCR      = 2'b01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic [1:0]  arburst = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [1:0]  awburst = '0;
  logic [7:0]  awlen = '0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic        wlast = 1'b0;
  logic [7:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  always #5 clk = ~clk;

  axi_burst_mem_slave #(
    .DATA_WIDTH(64), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arburst(arburst), .arlen(arlen), .arsize(arsize),
    .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awburst(awburst), .awlen(awlen), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Reference memory image, updated whenever the bench issues a write.
  logic [63:0] model_mem [MEM_WORDS];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(MEM_WORDS * 8));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  // Address of beat b: start + b * bytes-per-beat for INCR, start otherwise.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int b,
                                            input int bytes, input logic [1:0] burst);
    return (burst == INCR) ? start + 32'(b * bytes) : start;
  endfunction

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input bit stall, input int abort_beat,
                         output logic [63:0] first_data);
    int guard;
    bit ok;
    logic [31:0] ba;
    logic [1:0]  er;
    logic [63:0] ed;
    first_data = '0;
    $display("RD addr=%h len=%0d size=%0d burst=%0d stall=%0d abort=%0d",
             addr, len, size, burst, stall, abort_beat);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 50) begin
      ok = arready; @(posedge clk); #1; guard++;
    end
    arvalid = 1'b0;
    if (!ok) begin check("ar_handshake_timeout", 0, 1); return; end
    guard = 0;
    while (!rvalid && guard < 50) begin @(posedge clk); #1; guard++; end
    check("rd_latency", 64'(guard), 64'(RL - 1));
    for (int b = 0; b <= int'(len); b++) begin
      guard = 0;
      while (!rvalid && guard < 50) begin @(posedge clk); #1; guard++; end
      if (!rvalid) begin check("rvalid_timeout", 0, 1); return; end
      ba = beat_addr(addr, b, 1 << size, burst);
      er = !in_range(ba) ? 2'b11 : burst[1] ? 2'b10 : 2'b00;
      ed = (er == 2'b00) ? model_mem[widx(ba)] : 64'd0;
      if (b == abort_beat) begin
        rst = 1'b0; #1;
        check("rst_rvalid", 64'(rvalid), 0);
        check("rst_arready", 64'(arready), 1);
        check("rst_rlast", 64'(rlast), 0);
        check("rst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst = 1'b1; rready = 1'b0;
        return;
      end
      if (stall) begin
        rready = 1'b0;
        check($sformatf("rdata_pre_stall[%0d]", b), rdata, ed);
        @(posedge clk); #1;
        check($sformatf("rvalid_stall[%0d]", b), 64'(rvalid), 1);
      end
      rready = 1'b1;
      check($sformatf("rdata[%0d]", b), rdata, ed);
      check($sformatf("rresp[%0d]", b), 64'(rresp), 64'(er));
      check($sformatf("rlast[%0d]", b), 64'(rlast), 64'(b == int'(len)));
      if (b == 0) first_data = rdata;
      @(posedge clk); #1;
      rready = 1'b0;
    end
    check("rd_done_rvalid", 64'(rvalid), 0);
    check("rd_done_arready", 64'(arready), 1);
  endtask

  // dmode: 0 random data, 1 dbase+beat, 2 beat*0x1111. strb==0 means random strobes.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int dmode, input logic [63:0] dbase, input logic [7:0] strb,
                          input int last_beat, input bit gaps);
    int guard;
    bit ok;
    bit dec;
    bit slv;
    logic [31:0] ba;
    logic [63:0] d;
    logic [7:0]  s;
    logic [1:0]  eb;
    $display("WR addr=%h len=%0d burst=%0d strb=%h wlast_beat=%0d", addr, len, burst, strb, last_beat);
    dec = 1'b0; slv = burst[1];
    awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 50) begin
      ok = awready; @(posedge clk); #1; guard++;
    end
    awvalid = 1'b0;
    if (!ok) begin check("aw_handshake_timeout", 0, 1); return; end
    for (int b = 0; b <= int'(len); b++) begin
      d = (dmode == 0) ? {$urandom, $urandom} :
          (dmode == 1) ? dbase + 64'(b) : 64'(b) * 64'h1111;
      s = (strb == 8'h00) ? 8'($urandom) : strb;
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0; @(posedge clk); #1;
      end
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = (b == last_beat);
      ok = 1'b0; guard = 0;
      while (!ok && guard < 50) begin
        ok = wready; @(posedge clk); #1; guard++;
      end
      if (!ok) begin check("wready_timeout", 0, 1); wvalid = 1'b0; return; end
      ba = beat_addr(addr, b, 8, burst);
      if (in_range(ba)) begin
        for (int i = 0; i < 8; i++)
          if (s[i]) model_mem[widx(ba)][8*i +: 8] = d[8*i +: 8];
      end else begin
        dec = 1'b1;
      end
      if ((b == last_beat) != (b == int'(len))) slv = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    eb = dec ? 2'b11 : slv ? 2'b10 : 2'b00;
    check("bvalid_after_last", 64'(bvalid), 1);
    bready = 1'b1;
    check("bresp", 64'(bresp), 64'(eb));
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clear", 64'(bvalid), 0);
    check("awready_back", 64'(awready), 1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [63:0] fd;
    logic [63:0] fd2;
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  sz;
    logic [1:0]  bt;
    int          lb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_arready", 64'(arready), 1);
    check("reset_awready", 64'(awready), 1);
    check("reset_rvalid", 64'(rvalid), 0);
    check("reset_rlast", 64'(rlast), 0);
    check("reset_wready", 64'(wready), 0);
    check("reset_bvalid", 64'(bvalid), 0);
    check("reset_rdata", rdata, 0);
    check("reset_rresp", 64'(rresp), 0);
    check("reset_bresp", 64'(bresp), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fill the whole array so every later read has a known expectation.
    for (int k = 0; k < MEM_WORDS / 256; k++)
      do_write(BASE + 32'(k * 2048), 8'd255, INCR, 0, 0, 8'hFF, 255, 1'b0);

    // mem[0..7] = i*0x1111, read back as one INCR burst
    do_write(BASE, 8'd7, INCR, 2, 0, 8'hFF, 7, 1'b0);
    do_read(BASE, 8'd7, 3'd3, INCR, 1'b0, -1, fd);
    check("preload_word0", fd, 64'h0);

    // 0xA0..0xA7 at 0x80000040
    do_write(BASE + 32'h40, 8'd7, INCR, 1, 64'hA0, 8'hFF, 7, 1'b0);
    do_read(BASE + 32'h40, 8'd7, 3'd3, INCR, 1'b0, -1, fd);
    check("a0_word0", fd, 64'hA0);

    // Byte-strobe merge
    do_write(BASE + 32'h100, 8'd0, INCR, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);
    do_write(BASE + 32'h100, 8'd0, INCR, 1, 64'h1122_3344_5566_7788, 8'h0F, 0, 1'b0);
    do_read(BASE + 32'h100, 8'd0, 3'd3, INCR, 1'b0, -1, fd);
    check("strb_merge", fd, 64'hFFFF_FFFF_5566_7788);

    // Stalled read: rready toggled every cycle
    do_read(BASE + 32'h40, 8'd7, 3'd3, INCR, 1'b1, -1, fd);

    // Out-of-range read and write; wlast early gives SLVERR
    do_read(32'h0000_1000, 8'd3, 3'd3, INCR, 1'b0, -1, fd);
    do_write(32'h0000_1000, 8'd3, INCR, 0, 0, 8'hFF, 3, 1'b0);
    do_write(BASE + 32'h200, 8'd3, INCR, 0, 0, 8'hFF, 1, 1'b0);
    do_read(BASE + 32'h200, 8'd3, 3'd3, INCR, 1'b0, -1, fd);

    // Bursts crossing the top of the array, FIXED and reserved bursts
    do_read(BASE + 32'((MEM_WORDS - 2) * 8), 8'd3, 3'd3, INCR, 1'b0, -1, fd);
    do_write(BASE + 32'((MEM_WORDS - 1) * 8), 8'd2, INCR, 0, 0, 8'h00, 2, 1'b0);
    do_read(BASE + 32'h300, 8'd3, 3'd3, FIXED, 1'b0, -1, fd);
    do_read(BASE + 32'h300, 8'd1, 3'd3, 2'b11, 1'b0, -1, fd);

    // AR and AW issued in the same cycle on disjoint regions
    fork
      do_read(BASE + 32'h800, 8'd5, 3'd3, INCR, 1'b1, -1, fd);
      do_write(BASE + 32'h1000, 8'd5, INCR, 0, 0, 8'h00, 5, 1'b1);
    join
    do_read(BASE + 32'h1000, 8'd5, 3'd3, INCR, 1'b0, -1, fd);

    // Reset during the third beat, then a clean burst
    do_read(BASE, 8'd7, 3'd3, INCR, 1'b0, 2, fd);
    check("post_rst_awready", 64'(awready), 1);
    do_read(BASE, 8'd7, 3'd3, INCR, 1'b0, -1, fd2);
    check("post_rst_word0", fd2, model_mem[0]);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      a  = ($urandom_range(0, 9) == 0) ? 32'h0000_2000 : BASE;
      a  = a + 32'($urandom_range(0, MEM_WORDS - 1) * 8);
      l  = 8'($urandom_range(0, 15));
      bt = ($urandom_range(0, 1) == 1) ? INCR : FIXED;
      if ($urandom_range(0, 1) == 1) begin
        sz = 3'($urandom_range(0, 3));
        a  = a + ((32'($urandom_range(0, 7)) >> sz) << sz);
        do_read(a, l, sz, bt, 1'($urandom_range(0, 1)), -1, fd);
      end else begin
        lb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, int'(l)) : int'(l);
        do_write(a, l, bt, 0, 0, 8'h00, lb, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_mem_slave.md
Name: axi_burst_mem_slave

Overview:
AXI4-style burst responder that models main memory for the data-cache refill/writeback path. It accepts the cache's AR/R and AW/W/B channels, serves INCR/FIXED bursts from an internal word array, and applies byte-strobed writes. Read and write channels run independently, each with its own state machine, and are used as the NPC simulation memory endpoint.

Parameters:
DATA_WIDTH, 64, beat width in bits (fixed 64; strobe width 8)
MEM_WORDS, 1024, number of 64-bit words (8 KiB)
BASE_ADDR, 32'h80000000, byte address of word 0
READ_LATENCY, 2, cycles from AR handshake to first rvalid (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
araddr  in  32  read burst start byte address
arvalid  in  1  read address valid
arburst  in  2  00 FIXED, 01 INCR, others reserved
arlen  in  8  beats-1
arsize  in  3  log2 bytes per beat (0..3)
arready  out  1  read address ready
rdata  out  64  read beat data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rvalid  out  1  read data valid
rlast  out  1  final read beat
rready  in  1  read data ready
awaddr  in  32  write burst start byte address
awvalid  in  1  write address valid
awburst  in  2  as arburst
awlen  in  8  beats-1
awready  out  1  write address ready
wdata  in  64  write beat data
wlast  in  1  master's last-beat flag
wstrb  in  8  byte enables
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready

Behaviour:
- Reset (rst low, async): both FSMs to IDLE; arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rdata=0, rresp=0, bresp=0, counters 0. Memory array not cleared.
- Word index = (addr-BASE_ADDR)>>3. Address out of [BASE_ADDR, BASE_ADDR+8*MEM_WORDS) -> DECERR.
- Beat count = len+1 (1..256). Address step per beat: INCR += 1<<size, FIXED += 0. Reserved burst -> SLVERR, burst still runs full length.
- Read FSM: R_IDLE (arready=1) -> on arvalid&arready latch addr/len/size/burst, go R_WAIT; R_WAIT counts READ_LATENCY-1 cycles, then R_DATA. R_DATA: rvalid=1, rdata=mem[word] (0 on error), rlast=1 when beat counter==len; on rvalid&rready advance address/counter; on final handshake -> R_IDLE, arready=1 next cycle. rdata/rresp/rlast stable while rvalid&!rready.
- Per-beat rresp: DECERR if that beat's address out of range, else SLVERR if reserved burst, else OKAY.
- Write FSM: W_IDLE (awready=1) -> on awvalid&awready latch, W_DATA (wready=1). Each wvalid&wready: bytes with wstrb[i]=1 written to mem[word][8i+7:8i] if in range, else dropped and DECERR flagged; counter advances. Burst ends on internal counter==len (wlast not used for termination); if wlast disagrees with counter on any beat -> SLVERR flagged. Then W_RESP: bvalid=1, bresp = DECERR > SLVERR > OKAY (sticky flags), held until bready; -> W_IDLE.
- Simultaneous read beat and write to same word same cycle: read returns pre-write data.
- AR and AW may be accepted in the same cycle; no ordering between channels.
- Reset mid-burst: transaction abandoned, partially written words remain written.

Test Plan:
- Preload mem[0..7]=i*0x1111; AR araddr=0x80000000 len=7 size=3 INCR, rready=1 -> first rvalid 2 cycles after AR handshake, 8 beats 0x0,0x1111..0x7777, rlast only on beat 8, rresp=00.
- AW 0x80000040 len=7, W data 0xA0..0xA7, wstrb=0xFF, wlast on beat 8, bready=1 -> bresp=00 one cycle after last beat; readback returns 0xA0..0xA7.
- Write wstrb=0x0F data 0x1122334455667788 over word 0xFFFFFFFFFFFFFFFF -> word reads 0xFFFFFFFF55667788.
- Read with rready toggled 1/0 each cycle -> rdata/rlast held stable while stalled, 8 beats in order.
- araddr=0x00001000 len=3 -> 4 beats rdata=0, rresp=11; AW in range with wlast on beat 2 of 4 -> bresp=10.
- Assert rst low mid-read beat 3 -> rvalid=0, arready=1 immediately; new burst after release completes normally.
